// File: rtl/fa_bist_pkg.sv
// rtl/fa_bist_pkg.sv - shared state encoding and constants for the full-adder BIST
package fa_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int ERR_W = 4;
    localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

endpackage

// File: rtl/fa_bist_golden.sv
// rtl/fa_bist_golden.sv - reference sum/carry for one full-adder vector (a, b, cin -> exp_s, exp_c)
module fa_bist_golden (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic exp_s,
    output logic exp_c
);

    assign exp_s = a ^ b ^ cin;
    assign exp_c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_bist.sv
// rtl/fa_bist.sv - full-adder BIST sweep/check controller; FA_BIST_ERRLOG_EN adds fail_valid/fail_vec
module fa_bist
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_cin,
    input  logic             dut_sout,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef FA_BIST_ERRLOG_EN
    ,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LOOP_LAST   = 4'(LOOPS - 1);
    localparam logic [2:0] IDX_LAST    = 3'(NUM_VECTORS - 1);

    state_t           state, state_nx;
    logic [2:0]       idx, idx_nx;
    logic [3:0]       loop_cnt;
    logic [3:0]       wait_cnt;
    logic [2:0]       vec;
    logic [ERR_W-1:0] errs;
    logic             exp_s, exp_c;
    logic             accept, last_vec, sample, mismatch;

    fa_bist_golden u_golden (
        .a     (vec[2]),
        .b     (vec[1]),
        .cin   (vec[0]),
        .exp_s (exp_s),
        .exp_c (exp_c)
    );

    assign accept   = (state == ST_IDLE || state == ST_DONE) && start && !abort;
    assign last_vec = (idx == IDX_LAST) && (loop_cnt == LOOP_LAST);
    // An abort landing in CHECK cancels that vector's sample as well.
    assign sample   = (state == ST_CHECK) && !abort;
    assign mismatch = (dut_sout != exp_s) || (dut_cout != exp_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: if (start) state_nx = ST_APPLY;
                ST_APPLY:         state_nx = ST_WAIT;
                ST_WAIT:          if (wait_cnt == SETTLE_LAST) state_nx = ST_CHECK;
                ST_CHECK:         state_nx = last_vec ? ST_DONE : ST_APPLY;
                default:          state_nx = ST_IDLE;
            endcase
        end
        if (accept) begin
            idx_nx = 3'd0;
        end else if (sample && !last_vec) begin
            idx_nx = idx + 3'd1;  // natural 7 -> 0 wrap at loop boundaries
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 3'd0;
            loop_cnt <= 4'd0;
            wait_cnt <= 4'd0;
            vec      <= 3'd0;
            errs     <= '0;
        end else begin
            idx <= idx_nx;
            if (accept) begin
                loop_cnt <= 4'd0;
                errs     <= '0;
            end else if (sample) begin
                if (mismatch && errs != ERR_MAX) errs <= errs + 1'b1;
                if (!last_vec && idx == IDX_LAST) loop_cnt <= loop_cnt + 4'd1;
            end
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
            // Vector is a register so the adder sees clean levels for the whole slot.
            if (state_nx == ST_APPLY) begin
                vec <= idx_nx;
            end else if (state_nx == ST_IDLE || state_nx == ST_DONE) begin
                vec <= 3'd0;
            end
        end
    end

`ifdef FA_BIST_ERRLOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else if (accept) begin
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else if (sample && mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= idx;
        end
    end
`endif

    assign dut_a     = vec[2];
    assign dut_b     = vec[1];
    assign dut_cin   = vec[0];
    assign busy      = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_CHECK);
    assign done      = (state == ST_DONE);
    assign pass      = done && (errs == '0);
    assign err_count = errs;

endmodule

// File: tb/tb_fa_bist.sv
// tb/tb_fa_bist.sv - scoreboard bench for fa_bist with a fault-injectable full-adder model
module tb_fa_bist;

    typedef struct {
        int t0;
        int lat;
        int err;
        int pass_v;
        int fvalid;
        int fvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, abort, start2;
    int   cyc = 0;
    int   fault_mode;
    int   checks = 0;
    int   errors = 0;
    int   t0;
    exp_t q1[$];
    exp_t q2[$];

    logic       a, b, cin, sout, cout, busy, done, pass;
    logic [3:0] err_count;
    logic       a2, b2, cin2, sout2, cout2, busy2, done2, pass2;
    logic [3:0] err_count2;
`ifdef FA_BIST_ERRLOG_EN
    logic       fail_valid, fail_valid2;
    logic [2:0] fail_vec, fail_vec2;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder under test: 1 = sum stuck at 0, 2 = carry inverted.
    always_comb begin
        sout = (fault_mode == 1) ? 1'b0 : (a ^ b ^ cin);
        cout = ((a & b) | (a & cin) | (b & cin)) ^ (fault_mode == 2);
    end
    assign sout2 = a2 ^ b2 ^ cin2;
    assign cout2 = ~((a2 & b2) | (a2 & cin2) | (b2 & cin2));

    fa_bist dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dut_a     (a),
        .dut_b     (b),
        .dut_cin   (cin),
        .dut_sout  (sout),
        .dut_cout  (cout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
`ifdef FA_BIST_ERRLOG_EN
        ,
        .fail_valid(fail_valid),
        .fail_vec  (fail_vec)
`endif
    );

    fa_bist #(.SETTLE_CYCLES(2), .LOOPS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .abort     (1'b0),
        .dut_a     (a2),
        .dut_b     (b2),
        .dut_cin   (cin2),
        .dut_sout  (sout2),
        .dut_cout  (cout2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_count (err_count2)
`ifdef FA_BIST_ERRLOG_EN
        ,
        .fail_valid(fail_valid2),
        .fail_vec  (fail_vec2)
`endif
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic push1(input int ts, input int lat, input int err, input int p,
                         input int fv, input int fvec);
        exp_t e;
        e.t0 = ts; e.lat = lat; e.err = err; e.pass_v = p; e.fvalid = fv; e.fvec = fvec;
        q1.push_back(e);
    endtask

    task automatic do_start(output int ts);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ts = cyc;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            chk("drain_timeout", 1, 0);
            q1.delete();
            q2.delete();
        end
        @(negedge clk);
        #1;
    endtask

    logic done_q = 1'b0;
    always @(negedge clk) begin : mon1
        exp_t e;
        if (done && !done_q) begin
            if (q1.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("latency", cyc - e.t0, e.lat);
                chk("err_count", int'(err_count), e.err);
                chk("pass", int'(pass), e.pass_v);
`ifdef FA_BIST_ERRLOG_EN
                chk("fail_valid", int'(fail_valid), e.fvalid);
                if (e.fvalid != 0) chk("fail_vec", int'(fail_vec), e.fvec);
`endif
            end
        end
        done_q <= done;
    end

    logic done2_q = 1'b0;
    always @(negedge clk) begin : mon2
        exp_t e;
        if (done2 && !done2_q) begin
            if (q2.size() == 0) begin
                chk("unexpected_done2", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("latency2", cyc - e.t0, e.lat);
                chk("err_count2", int'(err_count2), e.err);
                chk("pass2", int'(pass2), e.pass_v);
`ifdef FA_BIST_ERRLOG_EN
                chk("fail_valid2", int'(fail_valid2), e.fvalid);
                if (e.fvalid != 0) chk("fail_vec2", int'(fail_vec2), e.fvec);
`endif
            end
        end
        done2_q <= done2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        exp_t e2;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 0);
        chk("reset_err", int'(err_count), 0);
        chk("reset_vec", int'({a, b, cin}), 0);
        @(negedge clk) rst_n = 1'b1;

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        chk("sa_idle_busy", int'(busy), 0);
        chk("sa_idle_done", int'(done), 0);
        @(posedge clk);
        #1;
        chk("sa_idle_busy_next", int'(busy), 0);

        // good adder, walk the 8 vector slots
        fault_mode = 0;
        do_start(t0);
        push1(t0, 32, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            chk("walk_vec", int'({a, b, cin}), k);
            chk("walk_busy", int'(busy), 1);
            repeat (4) @(posedge clk);
            #1;
        end
        chk("end_done", int'(done), 1);
        chk("end_busy", int'(busy), 0);
        chk("end_vec", int'({a, b, cin}), 0);
        wait_drain();

        // sum stuck at 0: vectors 1,2,4,7 mismatch, first is 1
        fault_mode = 1;
        do_start(t0);
        push1(t0, 32, 4, 0, 1, 1);
        wait_drain();

        // start+abort from DONE: back to IDLE, count kept
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        chk("sa_done_done", int'(done), 0);
        chk("sa_done_busy", int'(busy), 0);
        chk("sa_done_err", int'(err_count), 4);

        // carry inverted: every vector mismatches
        fault_mode = 2;
        do_start(t0);
        push1(t0, 32, 8, 0, 1, 0);
        wait_drain();

        // start re-pulsed mid-run is ignored
        fault_mode = 0;
        do_start(t0);
        push1(t0, 32, 0, 1, 0, 0);
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain();

        // abort at cycle 10 after two faulty checks
        fault_mode = 2;
        do_start(t0);
        repeat (9) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_vec", int'({a, b, cin}), 0);
        chk("abort_err", int'(err_count), 2);
        @(posedge clk);
        #1;
        chk("abort_busy_next", int'(busy), 0);

        // reset in the middle of a faulty run
        fault_mode = 1;
        do_start(t0);
        repeat (16) @(posedge clk);
        #1;
        chk("pre_reset_err", int'(err_count), 2);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_err", int'(err_count), 0);
        chk("mid_reset_vec", int'({a, b, cin}), 0);
        chk("mid_reset_done", int'(done), 0);
        @(negedge clk) rst_n = 1'b1;
        fault_mode = 0;
        do_start(t0);
        chk("post_reset_busy", int'(busy), 1);
        push1(t0, 32, 0, 1, 0, 0);
        wait_drain();

        // two loops with carry inverted saturate the count
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        e2.t0 = cyc; e2.lat = 64; e2.err = 15; e2.pass_v = 0; e2.fvalid = 1; e2.fvec = 0;
        q2.push_back(e2);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
